rgb_sequencer: RTL
==================

# rgb_sequencer

Color-sequencing stage that consumes the one-cycle `positive_edge` pulse from the button debouncer/edge-detector chain and drives the board's 3-bit RGB LED. Each step pulse advances a fixed 8-color sequence. An optional auto-advance timer steps the sequence periodically without button presses. An optional PWM dimmer reduces LED brightness. The block sits directly after `edge_detector_moore` in `main`, and its `rgb` output goes straight to the top-level `rgb` port.

## Interface
- `AUTO_TICKS`, default 12_000_000: clock cycles per automatic advance; legal range 2 and up.
- `PWM_BITS`, default 4: width of the free-running PWM counter.
- `DUTY`, default 4: cycles per PWM period during which LEDs are on when dimmed; legal range 0 .. 2^PWM_BITS-1.
- `clk`, input, 1: system clock; the block has one clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `step`, input, 1: single-cycle advance request (edge-detector output).
- `auto_en`, input, 1: level; 1 enables timed auto-advance.
- `dim`, input, 1: level; 1 gates `rgb` with the PWM duty cycle.
- `rgb`, output, 3: LED drive; bit 2 is R, bit 1 is G, bit 0 is B; active-high.
- `index`, output, 3: current sequence position, 0–7.
- `wrapped`, output, 1: one-cycle pulse when the sequence returns from 7 to 0.

## Operation
- **State machine**, 8 states, in this order, encoded as `index`:
  - BLACK = 0 (000), RED = 1 (100), GREEN = 2 (010), BLUE = 3 (001)
  - YELLOW = 4 (110), CYAN = 5 (011), MAGENTA = 6 (101), WHITE = 7 (111)
- **Advance:** an advance moves the state to `index+1` mod 8.
  - WHITE goes to BLACK.
  - The advance that takes WHITE to BLACK sets `wrapped` = 1 for exactly one cycle.
- **Advance sources:**
  - `step` = 1 at a clock edge.
  - Auto-timer expiry.
  - Both sources in the same cycle produce one advance, never two.
- **Auto timer:** a `$clog2(AUTO_TICKS)`-bit counter.
  - When `auto_en` = 0, the counter is forced to 0 every cycle.
  - When `auto_en` = 1, it increments each cycle. When it equals AUTO_TICKS-1, it reloads 0 and an advance occurs.
  - A `step` clears the counter to 0 in the same edge, so the next auto advance is a full AUTO_TICKS cycles later.
- **PWM:** a `PWM_BITS`-bit counter.
  - It is free-running, wraps from 2^PWM_BITS-1 to 0, and is unaffected by `dim`, `step`, and `auto_en`.
  - `dim` = 0: `rgb` = color of the current state.
  - `dim` = 1: `rgb` = color when `pwm_count < DUTY`, else 000.
  - DUTY = 0 with `dim` = 1 gives a constant 000.
- **Glitch-free outputs:** `rgb`, `index`, and `wrapped` are decoded from registers only. No input feeds an output combinationally.
- **Reset:** `rst` = 1 at an edge sets:
  - state to BLACK, auto counter to 0, PWM counter to 0, `wrapped` to 0.
  - Resulting outputs: `rgb` = 000, `index` = 0.
  - `rst` overrides `step` and timer expiry in the same cycle.
  - Reset mid-sequence discards the position; no advance is pending afterwards.

## Timing
- **Step latency:** `step` sampled high at edge N makes the new `index` and `rgb` visible after edge N (1-cycle latency from assertion).
- **`wrapped` timing:** asserted after the same edge that loads BLACK from WHITE. Deasserted after the next edge unless another wrap occurs.
- **Auto period:** with `auto_en` held at 1 from reset release, advances occur after edges AUTO_TICKS, 2·AUTO_TICKS, and so on, counted from the first edge with `rst` = 0.
- **Auto enable/disable:**
  - Deasserting `auto_en` for any single cycle restarts the period.
  - Re-enabling does not cause an immediate advance.
- **PWM period:** 2^PWM_BITS cycles; on-time is DUTY cycles starting at `pwm_count` = 0.
- **`step` is edge-triggered:** a `step` held high for k cycles gives k advances. The block does not re-edge-detect.

## Test plan
Parameters for all scenarios: AUTO_TICKS = 4, PWM_BITS = 2, DUTY = 1.
- **Reset values:** hold `rst` 2 cycles, then release → `rgb` = 000, `index` = 0, `wrapped` = 0. With `auto_en` = 0, these stay constant for 20 cycles.
- **Manual sequence and wrap:** 8 single-cycle `step` pulses spaced 3 cycles apart → `rgb` reads 100, 010, 001, 110, 011, 101, 111, 000. `wrapped` is high for exactly 1 cycle, after the 8th pulse only.
- **Auto advance and timer restart:**
  - `auto_en` = 1 from reset release → `index` increments after edges 4, 8, 12.
  - Inject `step` at edge 6 → advance at edge 6. The next auto advance is at edge 10, not 8.
- **Simultaneous sources:** `step` coincident with timer expiry → `index` increases by exactly 1.
- **Dimming:** `dim` = 1 in RED state → `rgb` = 100 for 1 cycle, then 000 for 3 cycles, repeating. `dim` = 0 → constant 100.
- **Reset mid-operation:** assert `rst` in CYAN state together with a `step` pulse → `index` = 0, `rgb` = 000, and the first auto advance comes 4 cycles after release.

Source files
------------

// File: rtl/rgb_sequencer.sv
// ============================================================================
// Module      : rgb_sequencer
// Description : Steps a 3-bit RGB LED through a fixed 8-colour sequence.
//               A step pulse (from the debouncer/edge-detector chain) or an
//               optional auto-advance timer moves the sequence forward, and
//               an optional PWM dimmer gates the LED drive.
//
// Parameters  : AUTO_TICKS - clock cycles per automatic advance (>= 2)
//               PWM_BITS   - width of the free-running PWM counter
//               DUTY       - on-cycles per PWM period while dimmed
//                            (0 .. 2**PWM_BITS-1)
//
// Ports       : clk     in   system clock
//               rst     in   synchronous active-high reset
//               step    in   single-cycle advance request
//               auto_en in   level, enables timed auto-advance
//               dim     in   level, gates rgb with the PWM duty cycle
//               rgb     out  [2]=R [1]=G [0]=B, active-high
//               index   out  current sequence position 0..7
//               wrapped out  one-cycle pulse on the WHITE -> BLACK advance
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_sequencer #(
    parameter int AUTO_TICKS = 12_000_000,
    parameter int PWM_BITS   = 4,
    parameter int DUTY       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       auto_en,
    input  logic       dim,
    output logic [2:0] rgb,
    output logic [2:0] index,
    output logic       wrapped
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_cnt_w = $clog2(AUTO_TICKS);

    localparam logic [c_cnt_w-1:0]  c_tick_last = c_cnt_w'(AUTO_TICKS - 1);
    localparam logic [PWM_BITS-1:0] c_duty      = PWM_BITS'(DUTY);

    // Sequence states; the encoding doubles as the index output.
    localparam logic [2:0] c_st_black   = 3'd0;
    localparam logic [2:0] c_st_red     = 3'd1;
    localparam logic [2:0] c_st_green   = 3'd2;
    localparam logic [2:0] c_st_blue    = 3'd3;
    localparam logic [2:0] c_st_yellow  = 3'd4;
    localparam logic [2:0] c_st_cyan    = 3'd5;
    localparam logic [2:0] c_st_magenta = 3'd6;
    localparam logic [2:0] c_st_white   = 3'd7;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [c_cnt_w-1:0]  r_auto_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_wrapped;
    logic                r_dim;

    logic                w_expire;
    logic                w_advance;
    logic                w_pwm_on;
    logic [2:0]          w_color;

    // ------------------------------------------------------------------
    // Advance sources. Step and expiry in the same cycle OR together, so
    // they can only ever produce a single advance.
    // ------------------------------------------------------------------
    assign w_expire  = auto_en && (r_auto_cnt == c_tick_last);
    assign w_advance = step || w_expire;

    // ------------------------------------------------------------------
    // Auto-advance timer. Held at zero while disabled so that re-enabling
    // always starts a full period. A step also restarts the period.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_auto_cnt <= '0;
        end else if (!auto_en) begin
            r_auto_cnt <= '0;
        end else if (step || w_expire) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequence state and wrap pulse. The 3-bit increment wraps WHITE to
    // BLACK naturally.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_black;
            r_wrapped <= 1'b0;
        end else begin
            if (w_advance) begin
                r_state <= r_state + 3'd1;
            end
            r_wrapped <= w_advance && (r_state == c_st_white);
        end
    end

    // ------------------------------------------------------------------
    // PWM counter (free-running) and registered dim request. The dim
    // level is registered so that no input reaches rgb combinationally.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_dim     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_dim     <= dim;
        end
    end

    // On-window comparison; a zero duty is a constant off so no
    // always-false comparison is built.
    generate
        if (DUTY == 0) begin : g_pwm_dark
            assign w_pwm_on = 1'b0;
        end else begin : g_pwm_cmp
            assign w_pwm_on = (r_pwm_cnt < c_duty);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Colour decode (R,G,B)
    // ------------------------------------------------------------------
    always_comb begin
        w_color = 3'b000;
        case (r_state)
            c_st_black:   w_color = 3'b000;
            c_st_red:     w_color = 3'b100;
            c_st_green:   w_color = 3'b010;
            c_st_blue:    w_color = 3'b001;
            c_st_yellow:  w_color = 3'b110;
            c_st_cyan:    w_color = 3'b011;
            c_st_magenta: w_color = 3'b101;
            c_st_white:   w_color = 3'b111;
            default:      w_color = 3'b000;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registers only
    // ------------------------------------------------------------------
    assign rgb     = w_color & {3{!r_dim || w_pwm_on}};
    assign index   = r_state;
    assign wrapped = r_wrapped;

endmodule

`default_nettype wire
